// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over valid/ready, packs bytes big-endian
// into 32-bit instruction words and issues one-cycle writes to instruction memory.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [10:0] NumWords,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WriteEnable,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [10:0] WordsWritten
);

    localparam logic [31:0] BASE_AL = {BASE_ADDR[31:2], 2'b00};
    localparam logic [11:0] DEPTH_W = 12'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] num_words_q, num_words_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] write_addr_q, write_addr_d;
    logic [10:0] words_q, words_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [10:0] words_inc;

    assign words_inc = words_q + 11'd1;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            num_words_q  <= '0;
            byte_cnt_q   <= '0;
            write_data_q <= '0;
            write_addr_q <= BASE_AL;
            words_q      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_words_q  <= num_words_d;
            byte_cnt_q   <= byte_cnt_d;
            write_data_q <= write_data_d;
            write_addr_q <= write_addr_d;
            words_q      <= words_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic: load control, byte packing and write sequencing.
    always_comb begin
        state_d      = state_q;
        num_words_d  = num_words_q;
        byte_cnt_d   = byte_cnt_q;
        write_data_d = write_data_q;
        write_addr_d = write_addr_q;
        words_d      = words_q;
        done_d       = done_q;
        error_d      = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if ({1'b0, NumWords} > DEPTH_W) begin
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end else if (NumWords == 11'd0) begin
                        // Done is raised on entry so it is visible during the DONE cycle.
                        error_d = 1'b0;
                        words_d = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        num_words_d  = NumWords;
                        error_d      = 1'b0;
                        done_d       = 1'b0;
                        words_d      = '0;
                        write_addr_d = BASE_AL;
                        byte_cnt_d   = '0;
                        state_d      = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (ByteValid) begin
                    unique case (byte_cnt_q)
                        2'd0: write_data_d[31:24] = ByteIn;
                        2'd1: write_data_d[23:16] = ByteIn;
                        2'd2: write_data_d[15:8]  = ByteIn;
                        2'd3: write_data_d[7:0]   = ByteIn;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d      = words_inc;
                write_addr_d = write_addr_q + 32'd4;
                byte_cnt_d   = '0;
                if (words_inc == num_words_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ByteReady    = (state_q == S_RECV);
    assign WriteEnable  = (state_q == S_WRITE);
    assign Busy         = (state_q == S_RECV) || (state_q == S_WRITE);
    assign Done         = done_q;
    assign Error        = error_q;
    assign WriteAddress = write_addr_q;
    assign WriteData    = write_data_q;
    assign WordsWritten = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [10:0] NumWords;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [10:0] WordsWritten;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(
        .DEPTH    (1024),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .NumWords    (NumWords),
        .ByteIn      (ByteIn),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error),
        .WordsWritten(WordsWritten)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every memory write strobe, sampled away from the rising edge.
    always @(negedge Clk) begin
        if (WriteEnable === 1'b1) begin
            wr_addr.push_back(WriteAddress);
            wr_data.push_back(WriteData);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        while (ByteReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ByteReady !== 1'b1) check("byte_ready_timeout", 32'(ByteReady), 32'd1);
        ByteIn    = b;
        ByteValid = 1'b1;
        tick();
        ByteValid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        push_byte(w[31:24]);
        push_byte(w[23:16]);
        push_byte(w[15:8]);
        push_byte(w[7:0]);
    endtask

    initial begin
        int unsigned base;
        int unsigned acc;
        logic [6:0] vpat;
        logic [7:0] sbytes[7];

        Reset     = 1'b0;
        Start     = 1'b0;
        NumWords  = '0;
        ByteIn    = '0;
        ByteValid = 1'b0;
        @(negedge Clk);
        tick();
        tick();

        // Reset state
        check("rst_ready", 32'(ByteReady), 32'd0);
        check("rst_we", 32'(WriteEnable), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_addr", WriteAddress, 32'h0);
        check("rst_data", WriteData, 32'h0);
        check("rst_words", 32'(WordsWritten), 32'd0);
        Reset = 1'b1;
        tick();

        // Basic two-word load
        Start    = 1'b1;
        NumWords = 11'd2;
        tick();
        Start = 1'b0;
        check("basic_ready", 32'(ByteReady), 32'd1);
        check("basic_busy", 32'(Busy), 32'd1);
        push_word(32'h2008_0005);
        check("basic_we0", 32'(WriteEnable), 32'd1);
        check("basic_ready_in_write", 32'(ByteReady), 32'd0);
        check("basic_addr0", WriteAddress, 32'h0);
        check("basic_data0", WriteData, 32'h2008_0005);
        push_word(32'h8C09_0004);
        check("basic_we1", 32'(WriteEnable), 32'd1);
        tick();
        check("basic_done", 32'(Done), 32'd1);
        check("basic_busy_done", 32'(Busy), 32'd0);
        check("basic_words", 32'(WordsWritten), 32'd2);
        tick();
        check("basic_done_sticky", 32'(Done), 32'd1);
        check("basic_nwrites", 32'(wr_addr.size()), 32'd2);
        check("basic_w0_addr", wr_addr[0], 32'h0);
        check("basic_w0_data", wr_data[0], 32'h2008_0005);
        check("basic_w1_addr", wr_addr[1], 32'h4);
        check("basic_w1_data", wr_data[1], 32'h8C09_0004);

        // Reset in the middle of a word
        Start    = 1'b1;
        NumWords = 11'd1;
        tick();
        Start = 1'b0;
        push_byte(8'hAA);
        push_byte(8'hBB);
        Reset = 1'b0;
        tick();
        tick();
        check("mid_rst_ready", 32'(ByteReady), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_done", 32'(Done), 32'd0);
        check("mid_rst_addr", WriteAddress, 32'h0);
        check("mid_rst_data", WriteData, 32'h0);
        check("mid_rst_words", 32'(WordsWritten), 32'd0);
        check("mid_rst_nwrites", 32'(wr_addr.size()), 32'd2);
        Reset = 1'b1;
        tick();

        // Zero-word load
        Start    = 1'b1;
        NumWords = 11'd0;
        tick();
        Start = 1'b0;
        check("zero_done", 32'(Done), 32'd1);
        check("zero_busy", 32'(Busy), 32'd0);
        tick();
        tick();
        check("zero_nwrites", 32'(wr_addr.size()), 32'd2);
        check("zero_done_sticky", 32'(Done), 32'd1);

        // Reload starts cleanly from the first byte
        Start    = 1'b1;
        NumWords = 11'd1;
        tick();
        Start = 1'b0;
        check("reload_done_clr", 32'(Done), 32'd0);
        push_word(32'h1122_3344);
        check("reload_we", 32'(WriteEnable), 32'd1);
        check("reload_addr", WriteAddress, 32'h0);
        check("reload_data", WriteData, 32'h1122_3344);
        tick();
        tick();

        // Handshake stalls: valid pattern 1,0,0,1,1,0,1
        Start    = 1'b1;
        NumWords = 11'd1;
        tick();
        Start  = 1'b0;
        vpat   = 7'b1011001;
        sbytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        acc    = 0;
        for (int i = 0; i < 7; i++) begin
            ByteValid = vpat[i];
            ByteIn    = sbytes[i];
            if (ByteValid && ByteReady) acc++;
            tick();
        end
        ByteValid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd4);
        check("stall_we", 32'(WriteEnable), 32'd1);
        check("stall_ready_in_write", 32'(ByteReady), 32'd0);
        check("stall_data", WriteData, 32'hA1A4_A5A7);
        tick();
        tick();

        // Oversized request is rejected
        Start    = 1'b1;
        NumWords = 11'd1025;
        tick();
        Start = 1'b0;
        check("big_error", 32'(Error), 32'd1);
        check("big_done_clr", 32'(Done), 32'd0);
        check("big_ready", 32'(ByteReady), 32'd0);
        check("big_busy", 32'(Busy), 32'd0);
        tick();
        check("big_ready_stays", 32'(ByteReady), 32'd0);

        // Full-depth load
        base     = wr_addr.size();
        Start    = 1'b1;
        NumWords = 11'd1024;
        tick();
        Start = 1'b0;
        check("full_error_clr", 32'(Error), 32'd0);
        for (int k = 0; k < 1024; k++) begin
            push_word(32'hC000_0000 | 32'(k));
        end
        tick();
        check("full_done", 32'(Done), 32'd1);
        tick();
        check("full_nwrites", 32'(wr_addr.size() - base), 32'd1024);
        check("full_first_addr", wr_addr[base], 32'h0);
        check("full_last_addr", wr_addr[base + 1023], 32'h0000_0FFC);
        check("full_last_data", wr_data[base + 1023], 32'hC000_03FF);
        check("full_words", 32'(WordsWritten), 32'd1024);

        // Start held high through a three-word load
        base     = wr_addr.size();
        Start    = 1'b1;
        NumWords = 11'd3;
        tick();
        NumWords = 11'd5;
        push_word(32'h0000_0001);
        push_word(32'h0000_0002);
        push_word(32'h0000_0003);
        check("held_we_last", 32'(WriteEnable), 32'd1);
        tick();
        check("held_done", 32'(Done), 32'd1);
        Start = 1'b0;
        tick();
        tick();
        check("held_busy", 32'(Busy), 32'd0);
        check("held_words", 32'(WordsWritten), 32'd3);
        check("held_nwrites", 32'(wr_addr.size() - base), 32'd3);
        check("held_last_addr", wr_addr[base + 2], 32'h8);
        check("held_done_sticky", 32'(Done), 32'd1);
        Start    = 1'b1;
        NumWords = 11'd1;
        tick();
        Start = 1'b0;
        check("restart_done_clr", 32'(Done), 32'd0);
        check("restart_busy", 32'(Busy), 32'd1);
        check("restart_words", 32'(WordsWritten), 32'd0);
        push_word(32'hDEAD_BEEF);
        check("restart_data", WriteData, 32'hDEAD_BEEF);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
